// File: rtl/amiga_pll_pkg.sv
// Shared types and defaults for the Amiga core PLL supervisor.
package amiga_pll_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 74250;  // 1 ms at 74.25 MHz
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_RETRY_W       = 4;

  // Largest of three phase lengths; sizes the single shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow asynchronous level signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values simply shift the input down the chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared to 0 by the async reset.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the core PLL reset, waits for and debounces lock, and holds
// the core in reset until lock has been stable for a full window.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   RESET_PLL | pll_rst asserted for RST_CYCLES, core held in reset
//   WAIT_LOCK | pll_rst released, waiting for lock (timeout -> retry)
//   STABLE    | lock seen, counting consecutive locked cycles
//   RUN       | core released; any lock drop restarts the PLL
module pll_lock_supervisor
  import amiga_pll_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RETRY_W       = DEF_RETRY_W
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               soft_reset,
  input  logic               clear_flags,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               pll_ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic lk_s;

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_count_q, retry_count_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               core_reset_n_q, core_reset_n_d;
  logic               pll_ready_q, pll_ready_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_sys (clk_74a),
    .rst_b   (reset_n),
    .d       (pll_locked),
    .q       (lk_s)
  );

  // Next state, shared counter, sticky flags and registered outputs.
  // Clears apply first so a same-cycle set/increment wins over them.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    lock_lost_d   = clear_flags ? 1'b0 : lock_lost_q;
    retry_count_d = clear_flags ? '0 : retry_count_q;

    if (soft_reset) begin
      state_d = RESET_PLL;
      if (state_q == RUN && !lk_s) lock_lost_d = 1'b1;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = RESET_PLL;
            if (retry_count_d != '1) retry_count_d = retry_count_d + RETRY_W'(1);
          end
        end
        STABLE: begin
          if (!lk_s) state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
        end
        RUN: begin
          cnt_d = cnt_q;
          if (!lk_s) begin
            state_d     = RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end
        default: state_d = RESET_PLL;
      endcase
    end

    // A soft reset in RESET_PLL restarts the pulse, so clear on it too.
    if (state_d != state_q || soft_reset) cnt_d = '0;

    pll_rst_d      = (state_d == RESET_PLL);
    core_reset_n_d = (state_d == RUN);
    pll_ready_d    = (state_d == RUN);
  end

  // State, counter, flags and outputs; reset_n aborts to the safe values.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RESET_PLL;
      cnt_q          <= '0;
      retry_count_q  <= '0;
      lock_lost_q    <= 1'b0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      pll_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_count_q  <= retry_count_d;
      lock_lost_q    <= lock_lost_d;
      pll_rst_q      <= pll_rst_d;
      core_reset_n_q <= core_reset_n_d;
      pll_ready_q    <= pll_ready_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_reset_n_q;
  assign pll_ready    = pll_ready_q;
  assign retry_count  = retry_count_q;
  assign lock_lost    = lock_lost_q;

endmodule
